cp0_ext: RTL and testbench
==========================

# cp0_ext

Parametrised coprocessor-0 for the pipelined MIPS core. It holds SR, Cause, EPC, BadVAddr, PRId and a Count/Compare timer, and arbitrates exception and interrupt requests. It accepts a configurable number of external interrupt lines, two software interrupts and an internal timer interrupt. It sits beside the M stage: it takes the victim PC, delay-slot flag and exception code, and returns `req` and `epc_out` to the flush/PC-select logic.

## Interface
- `N_HWINT`, default 5, number of external interrupt lines (1..5); line i maps to Cause.IP[10+i].
- `TIMER_EN`, default 1. When 1, Count/Compare and the timer interrupt exist. When 0, Count and Compare read 0 and TI is never set.
- `PRID`, default 32'h0000_0001, read-only PRId value.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  mtc0 write strobe.
- `addr`  in  5  CP0 register number. The same address is used for read and write.
- `wdata`  in  32  mtc0 data.
- `rdata`  out  32  mfc0 data. Combinational from `addr`.
- `vpc`  in  32  PC of the M-stage instruction.
- `bd_in`  in  1  M-stage instruction is in a delay slot.
- `exc_code`  in  5  M-stage exception code; 0 means none.
- `bad_vaddr_in`  in  32  faulting address for AdEL/AdES.
- `hw_int`  in  N_HWINT  level-sensitive external interrupts.
- `eret`  in  1  eret is committing in M.
- `epc_out`  out  32  current EPC register.
- `req`  out  1  take exception/interrupt this cycle. Combinational.

## Operation
- Register map and write masks:
  - 8 BadVAddr: read-only.
  - 9 Count: read/write.
  - 11 Compare: read/write.
  - 12 SR: only IM[15:8], EXL[1] and IE[0] are stored; other bits read 0.
  - 13 Cause: only IP[9:8] (software interrupts) are writable. BD[31], TI[30], IP[15:10] and ExcCode[6:2] are hardware-owned; other bits read 0.
  - 14 EPC: stored with bits [1:0] forced to 0.
  - 15 PRId: read-only.
  - Any other address reads 0; writes to it are ignored.
- Pending vector P[7:0]:
  - P[1:0] = Cause.IP[9:8].
  - P[2+i] = live `hw_int[i]`; bits with no line read 0.
  - P[7] = TI.
- Cause.IP[15:10] is registered from the hardware part of P every cycle.
- `int_req = |(P & IM) & IE & !EXL`.
- `exc_req = (exc_code != 0) & !EXL`.
- `req = int_req | exc_req`. Interrupt takes priority over exception.
- On the edge where `req` is 1:
  - EXL is set to 1.
  - BD is set to `bd_in`.
  - EPC is set to `bd_in ? vpc-4 : vpc` (word-aligned).
  - ExcCode is set to 0 if `int_req`, else `exc_code`.
  - If `exc_code` is 4 or 5 and `int_req` is 0, BadVAddr is set to `bad_vaddr_in`.
- `eret` clears EXL on the next edge.
- Timer (TIMER_EN=1):
  - Count increments by 1 every cycle, wrapping 32'hFFFF_FFFF to 0.
  - TI is set on the edge where the new Count equals Compare and Compare != 0. TI is sticky.
  - Writing Compare clears TI and loads Compare.
  - Writing Count loads `wdata`; there is no increment that cycle.

## Timing
- Reset: SR, Cause, EPC, BadVAddr, Count, Compare and TI all 0. `epc_out` = 0; `req` = 0 while `hw_int` is ignored (IE=0).
- Reset asserted mid-operation overrides every other update on that edge.
- Per-edge priority: reset > `req` capture > `eret` > mtc0 write.
- When `req` is 1, a concurrent `we` is suppressed, because the victim instruction does not commit.
- `eret` and `req` cannot both be 1, since `eret` implies EXL=1. If both are asserted anyway, `req` capture wins and EXL stays 1.
- mtc0 results are visible on `rdata` and `epc_out` the cycle after the write.
- An mtc0 to SR that sets IE with a pending masked-in interrupt raises `req` in the next cycle.
- `req` follows `hw_int` with zero latency. Cause.IP[15:10] reads the value one cycle old.
- TI is visible in P one cycle after the matching Count edge.

## Test plan
- Reset, then write SR=32'h0000_FC01 and Compare=10 → `rdata`@12 = 32'h0000_FC01. TI sets on the edge where Count becomes 10. `req`=1 with ExcCode=0 and Cause bit30=1. EXL=1 next cycle, and `req` drops.
- `exc_code`=4, `bd_in`=1, `vpc`=32'h3008, `bad_vaddr_in`=32'h1235 → EPC=32'h3004, BD=1, ExcCode=4, BadVAddr=32'h1235, `epc_out`=32'h3004.
- `hw_int[0]`=1 with IM[10]=1 and `exc_code`=10 in the same cycle → ExcCode=0 and BadVAddr unchanged.
- `we`=1 with addr 14 and `wdata`=32'h3007 in the same cycle as `req`=1 → EPC = captured victim PC, not 32'h3004. Next cycle, assert `eret` → EXL=0.
- Write Count=32'hFFFF_FFFE with Compare=1 → Count wraps to 0, then TI sets when Count=1. Writing Compare=5 clears TI.
- Writes to PRId and BadVAddr are ignored. SR=32'hFFFF_FFFF reads back 32'h0000_FF03. With TIMER_EN=0, address 9 reads 0 forever.

Source files
------------

// File: rtl/cp0_ext.sv
// cp0_ext: MIPS coprocessor 0 with SR/Cause/EPC/BadVAddr/PRId, Count/Compare timer and exception arbitration.
module cp0_ext #(
    parameter int          N_HWINT  = 5,
    parameter bit          TIMER_EN = 1'b1,
    parameter logic [31:0] PRID     = 32'h0000_0001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [31:0]        vpc,
    input  logic               bd_in,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        bad_vaddr_in,
    input  logic [N_HWINT-1:0] hw_int,
    input  logic               eret,
    output logic [31:0]        epc_out,
    output logic               req
);
    logic [7:0]  im;
    logic        exl, ie, bd, ti;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc;
    logic [31:0] epc, bad_vaddr, count, compare;
    logic [4:0]  hw_pad;
    logic [7:0]  pend;
    logic        int_req, exc_req, wr;
    logic [31:0] count_nxt, epc_cap;

    assign hw_pad    = 5'(hw_int);
    assign pend      = {ti, hw_pad, ip_sw};
    assign int_req   = |(pend & im) & ie & ~exl;
    assign exc_req   = (exc_code != 5'd0) & ~exl;
    assign req       = int_req | exc_req;
    // the victim instruction never commits, so its mtc0 is dropped
    assign wr        = we & ~req;
    assign count_nxt = (wr && addr == 5'd9) ? wdata : count + 32'd1;
    assign epc_cap   = bd_in ? vpc - 32'd4 : vpc;
    assign epc_out   = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            im        <= '0;
            exl       <= 1'b0;
            ie        <= 1'b0;
            bd        <= 1'b0;
            ti        <= 1'b0;
            ip_hw     <= '0;
            ip_sw     <= '0;
            exc       <= '0;
            epc       <= '0;
            bad_vaddr <= '0;
            count     <= '0;
            compare   <= '0;
        end else begin
            ip_hw <= pend[7:2];
            if (TIMER_EN) begin
                count <= count_nxt;
                if (wr && addr == 5'd11) begin
                    compare <= wdata;
                    ti      <= 1'b0;
                end else if (count_nxt == compare && compare != 32'd0) begin
                    ti <= 1'b1;
                end
            end
            if (req) begin
                exl <= 1'b1;
                bd  <= bd_in;
                epc <= {epc_cap[31:2], 2'b00};
                exc <= int_req ? 5'd0 : exc_code;
                if (!int_req && (exc_code == 5'd4 || exc_code == 5'd5))
                    bad_vaddr <= bad_vaddr_in;
            end else begin
                if (wr && addr == 5'd12) begin
                    im <= wdata[15:8];
                    ie <= wdata[0];
                end
                exl <= eret ? 1'b0 : (wr && addr == 5'd12) ? wdata[1] : exl;
                if (wr && addr == 5'd13)
                    ip_sw <= wdata[9:8];
                if (wr && addr == 5'd14)
                    epc <= {wdata[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        case (addr)
            5'd8:    rdata = bad_vaddr;
            5'd9:    rdata = count;
            5'd11:   rdata = compare;
            5'd12:   rdata = {16'd0, im, 6'd0, exl, ie};
            5'd13:   rdata = {bd, ti, 14'd0, ip_hw, ip_sw, 1'b0, exc, 2'b00};
            5'd14:   rdata = epc;
            5'd15:   rdata = PRID;
            default: rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_ext.sv
// tb_cp0_ext: directed table and sequences plus randomized run against a register-level reference model.
module tb_cp0_ext;
    logic        clk = 1'b0, reset = 1'b1, we = 1'b0, bd_in = 1'b0, eret = 1'b0;
    logic [4:0]  addr = '0, exc_code = '0, hw_int = '0;
    logic [31:0] wdata = '0, vpc = '0, bad_vaddr_in = '0;
    logic [31:0] rdata, epc_out, rdata0, epc_out0;
    logic        req, req0;
    int n_vec = 0, n_bad = 0;
    bit live = 0;

    logic [31:0] m_sr, m_cause, m_epc, m_bad, m_count, m_cmp;

    always #5 clk = ~clk;

    cp0_ext dut (.clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
                 .vpc(vpc), .bd_in(bd_in), .exc_code(exc_code), .bad_vaddr_in(bad_vaddr_in),
                 .hw_int(hw_int), .eret(eret), .epc_out(epc_out), .req(req));
    cp0_ext #(.TIMER_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
                 .rdata(rdata0), .vpc(vpc), .bd_in(bd_in), .exc_code(exc_code),
                 .bad_vaddr_in(bad_vaddr_in), .hw_int(hw_int), .eret(eret),
                 .epc_out(epc_out0), .req(req0));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [7:0] m_pend();
        return {m_cause[30], hw_int, m_cause[9:8]};
    endfunction

    function automatic logic m_int();
        return ((m_pend() & m_sr[15:8]) != 8'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || (exc_code != 5'd0 && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_0001;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_edge();
        logic [7:0]  p;
        logic        ir, rq, tiv, w;
        logic [31:0] nc;
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0; m_bad = 0; m_count = 0; m_cmp = 0;
            return;
        end
        p   = m_pend();
        ir  = m_int();
        rq  = m_req();
        w   = we && !rq;
        tiv = m_cause[30];
        nc  = (w && addr == 5'd9) ? wdata : m_count + 1;
        if (nc == m_cmp && m_cmp != 0) tiv = 1;
        if (w && addr == 5'd11) begin
            m_cmp = wdata;
            tiv = 0;
        end
        m_count = nc;
        m_cause[15:10] = p[7:2];
        m_cause[30] = tiv;
        if (rq) begin
            m_sr[1] = 1;
            m_cause[31] = bd_in;
            m_epc = (bd_in ? vpc - 4 : vpc) & ~32'd3;
            m_cause[6:2] = ir ? 5'd0 : exc_code;
            if (!ir && (exc_code == 5'd4 || exc_code == 5'd5)) m_bad = bad_vaddr_in;
        end else begin
            if (w && addr == 5'd12) m_sr = wdata & 32'h0000_FF03;
            if (w && addr == 5'd13) m_cause = (m_cause & ~32'h300) | (wdata & 32'h300);
            if (w && addr == 5'd14) m_epc = wdata & ~32'd3;
            if (eret) m_sr[1] = 0;
        end
    endfunction

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        if (live) begin
            chk("model_req", req, m_req());
            chk("model_epc", epc_out, m_epc);
            chk($sformatf("model_rd%0d", addr), rdata, m_rd(addr));
            if (addr == 5'd9 || addr == 5'd11) chk("notimer_rd", rdata0, 32'd0);
        end
        @(posedge clk);
        m_edge();
        live = 1;
        #1;
    endtask

    task automatic idle();
        we = 0; eret = 0; exc_code = 0; hw_int = 0; bd_in = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        we = 1; addr = a; wdata = d;
        settle();
        tick();
        we = 0;
    endtask

    task automatic rd(input string n, input logic [4:0] a, input logic [31:0] exp);
        idle();
        addr = a;
        settle();
        chk(n, rdata, exp);
    endtask

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[6];
    logic [4:0] addrs[9];

    initial begin
        tbl[0] = '{5'd15, 32'hDEAD_BEEF, 32'h0000_0001};
        tbl[1] = '{5'd8,  32'hFFFF_FFFF, 32'h0000_1235};
        tbl[2] = '{5'd3,  32'h1234_5678, 32'h0000_0000};
        tbl[3] = '{5'd14, 32'h0000_3007, 32'h0000_3004};
        tbl[4] = '{5'd12, 32'hFFFF_FFFF, 32'h0000_FF03};
        tbl[5] = '{5'd13, 32'hFFFF_FFFF, 32'h0000_0304};
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd0};

        // reset: hw_int held high must not raise req while IE=0
        reset = 1; hw_int = '1;
        settle();
        tick();
        reset = 0;
        settle();
        chk("rst_req", req, 0);
        chk("rst_epc", epc_out, 0);
        addr = 12; settle();
        chk("rst_sr", rdata, 0);

        // timer interrupt
        wr(12, 32'h0000_FC01);
        wr(11, 32'd10);
        rd("sr_fc01", 12, 32'h0000_FC01);
        for (int i = 0; i < 20 && req !== 1'b1; i++) begin
            tick();
            settle();
        end
        chk("ti_req", req, 1);
        addr = 13; settle();
        chk("ti_bit", rdata[30], 1);
        chk("ti_count", dut.count, 32'd10);
        tick();
        rd("ti_exccode", 13, {m_cause[31:7], 5'd0, 2'b00});
        chk("ti_exccode_zero", rdata[6:2], 0);
        chk("ti_req_drop", req, 0);
        rd("ti_exl", 12, 32'h0000_FC03);

        // address error in delay slot
        wr(11, 32'd0);
        idle(); eret = 1; settle(); tick();
        idle(); exc_code = 4; bd_in = 1; vpc = 32'h3008; bad_vaddr_in = 32'h1235;
        settle();
        chk("ade_req", req, 1);
        tick();
        rd("ade_bad", 8, 32'h0000_1235);
        chk("ade_epc", epc_out, 32'h3004);
        addr = 13; settle();
        chk("ade_bd", rdata[31], 1);
        chk("ade_exc", rdata[6:2], 4);

        // interrupt beats simultaneous exception
        idle(); eret = 1; settle(); tick();
        idle(); hw_int = 5'b00001; exc_code = 10; vpc = 32'h5000; bad_vaddr_in = 32'h9999;
        settle();
        chk("irq_req", req, 1);
        tick();
        rd("irq_bad_keep", 8, 32'h0000_1235);
        addr = 13; settle();
        chk("irq_exc", rdata[6:2], 0);

        // mtc0 EPC suppressed by concurrent exception, then eret
        idle(); eret = 1; settle(); tick();
        idle(); exc_code = 1; vpc = 32'h4000; we = 1; addr = 14; wdata = 32'h3007;
        settle();
        chk("sup_req", req, 1);
        tick();
        idle(); settle();
        chk("sup_epc", epc_out, 32'h4000);
        eret = 1; settle(); tick();
        rd("eret_exl", 12, 32'h0000_FC01);

        // count wrap and compare
        wr(12, 32'd0);
        wr(11, 32'd1);
        wr(9, 32'hFFFF_FFFE);
        rd("cnt_load", 9, 32'hFFFF_FFFE);
        chk("notimer_cnt", rdata0, 32'd0);
        tick(); tick();
        rd("cnt_wrap", 9, 32'd0);
        addr = 13; settle();
        chk("wrap_no_ti", rdata[30], 0);
        tick();
        addr = 13; settle();
        chk("ti_at_1", rdata[30], 1);
        wr(11, 32'd5);
        addr = 13; settle();
        chk("ti_clear", rdata[30], 0);
        chk("notimer_ti", rdata0[30], 0);
        wr(11, 32'd0);

        // register masks and read-only registers
        foreach (tbl[i]) begin
            wr(tbl[i].a, tbl[i].d);
            rd($sformatf("tbl%0d_a%0d", i, tbl[i].a), tbl[i].a, tbl[i].exp);
        end
        wr(12, 32'd0);

        // randomized run against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            addr = addrs[$urandom_range(0, 8)];
            we = ($urandom_range(0, 3) == 0);
            wdata = $urandom;
            if (addr == 5'd11) wdata = m_count + $urandom_range(2, 12);
            if (addr == 5'd12 && $urandom_range(0, 3) != 0) wdata[1] = 1'b0;
            exc_code = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            eret = m_sr[1] && ($urandom_range(0, 2) == 0);
            if (eret) we = 0;
            hw_int = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
            bd_in = 1'($urandom);
            vpc = $urandom;
            bad_vaddr_in = $urandom;
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
